turn_timer_ctrl: RTL and testbench

Two-requester turn scheduler that owns the game's shared 16-bit turn counter (`go`/`en` in, `count` out). It grants the counter to one requester at a time in round-robin order. It restarts the counter at the start of each turn and paces counting with a prescaled tick. It ends the turn on an early `done` or on expiry at `MAXCOUNT`. It sits between the player input logic and the counter instance.

---
 rtl/turn_timer_pkg.sv | 20 ++
 rtl/turn_timer_if.sv | 38 +++
 rtl/tick_prescaler.sv | 29 ++
 rtl/turn_timer_ctrl.sv | 109 ++++++++++
 tb/tb_turn_timer_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/turn_timer_pkg.sv
// turn_timer_pkg: shared types and defaults for the turn timer controller.
package turn_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    EXPIRE,
    RELEASE
  } tt_state_t;

  localparam logic [15:0] TT_MAXCOUNT_DEF = 16'd35264;
  localparam int          TT_TICK_DIV_DEF = 50000;

  // Converts a one-bit requester index into its one-hot grant vector.
  function automatic logic [1:0] tt_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/turn_timer_if.sv
// turn_timer_if: bundles the requester and counter signals of the turn timer.
// With TURN_TIMER_PAUSE_EN defined, a pause input to the controller is added.
interface turn_timer_if;

  logic [1:0]  req;
  logic [1:0]  done;
  logic [15:0] count;
  logic        cnt_go;
  logic        cnt_en;
  logic [1:0]  grant;
  logic        owner;
  logic        timeout;
  logic        busy;
`ifdef TURN_TIMER_PAUSE_EN
  logic        pause;

  modport master (
    output req, done, count, pause,
    input  cnt_go, cnt_en, grant, owner, timeout, busy
  );

  modport slave (
    input  req, done, count, pause,
    output cnt_go, cnt_en, grant, owner, timeout, busy
  );
`else
  modport master (
    output req, done, count,
    input  cnt_go, cnt_en, grant, owner, timeout, busy
  );

  modport slave (
    input  req, done, count,
    output cnt_go, cnt_en, grant, owner, timeout, busy
  );
`endif

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV and emits a one-cycle tick on the
// last phase. clear restarts the phase at 0; hold freezes it and masks tick.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int             W    = $clog2(TICK_DIV + 1);
  localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

  logic [W-1:0] phase;

  // Phase counter: wraps after LAST, frozen by hold, forced to 0 by clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (!hold) begin
      phase <= (phase == LAST) ? '0 : phase + W'(1);
    end
  end

  assign tick = (phase == LAST) && !hold && !clear;

endmodule

// File: rtl/turn_timer_ctrl.sv
// turn_timer_ctrl: two-requester round-robin turn scheduler driving the shared
// turn counter. Optional feature macro: TURN_TIMER_PAUSE_EN (adds pause).
module turn_timer_ctrl
  import turn_timer_pkg::*;
#(
  parameter logic [15:0] MAXCOUNT = TT_MAXCOUNT_DEF,
  parameter int          TICK_DIV = TT_TICK_DIV_DEF
) (
  input  logic           clk,
  input  logic           reset,
  turn_timer_if.slave    bus
);

  tt_state_t state;
  tt_state_t state_next;
  logic      owner_q;
  logic      owner_next;
  logic      rr_q;
  logic      rr_next;
  logic      tick;
  logic      hold;
  logic      pre_clear;

`ifdef TURN_TIMER_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  // The prescaler only runs in RUN; every other state keeps it at phase 0.
  assign pre_clear = (state != RUN);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (pre_clear),
    .hold  (hold),
    .tick  (tick)
  );

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state   <= state_next;
      owner_q <= owner_next;
      rr_q    <= rr_next;
    end
  end

  // Next-state, owner selection and output decode from registered state.
  always_comb begin
    state_next  = state;
    owner_next  = owner_q;
    rr_next     = rr_q;
    bus.cnt_go  = 1'b0;
    bus.cnt_en  = 1'b0;
    bus.grant   = 2'b00;
    bus.timeout = 1'b0;
    bus.busy    = (state != IDLE);
    bus.owner   = owner_q;

    case (state)
      IDLE: begin
        bus.cnt_go = 1'b1;
        if (bus.req != 2'b00) begin
          state_next = LOAD;
          case (bus.req)
            2'b01:   owner_next = 1'b0;
            2'b10:   owner_next = 1'b1;
            default: owner_next = rr_q;
          endcase
        end
      end
      LOAD: begin
        bus.cnt_go = 1'b1;
        bus.grant  = tt_onehot(owner_q);
        state_next = RUN;
      end
      RUN: begin
        bus.grant  = tt_onehot(owner_q);
        bus.cnt_en = tick;
        if (bus.count == MAXCOUNT) begin
          state_next = EXPIRE;
        end else if (bus.done[owner_q]) begin
          state_next = RELEASE;
        end
      end
      EXPIRE: begin
        bus.grant   = tt_onehot(owner_q);
        bus.timeout = 1'b1;
        state_next  = RELEASE;
      end
      RELEASE: begin
        rr_next    = ~owner_q;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// tb_turn_timer_ctrl: directed bench for turn_timer_ctrl with TICK_DIV=4,
// MAXCOUNT=3 and a behavioural turn counter (clear on go, +1 on en).
module tb_turn_timer_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   to_seen;
  int   en_seen;
  logic [15:0] cnt_model;

  turn_timer_if bus ();

  turn_timer_ctrl #(
    .MAXCOUNT (16'd3),
    .TICK_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural turn counter owned by the controller.
  always @(posedge clk) begin
    if (reset || bus.cnt_go) cnt_model <= 16'd0;
    else if (bus.cnt_en)     cnt_model <= cnt_model + 16'd1;
  end

  assign bus.count = cnt_model;

  // Pulse tallies for timeout and counter enables.
  always @(posedge clk) begin
    if (bus.timeout === 1'b1) to_seen <= to_seen + 1;
    if (bus.cnt_en === 1'b1)  en_seen <= en_seen + 1;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset values of all outputs.
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total += 6;
    if (bus.grant !== 2'b00) begin bad++; $display("[TB] FAIL rst_grant: got %b expected 00", bus.grant); end
    if (bus.cnt_go !== 1'b1) begin bad++; $display("[TB] FAIL rst_go: got %b expected 1", bus.cnt_go); end
    if (bus.cnt_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_en: got %b expected 0", bus.cnt_en); end
    if (bus.timeout !== 1'b0) begin bad++; $display("[TB] FAIL rst_timeout: got %b expected 0", bus.timeout); end
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy); end
    if (bus.owner !== 1'b0) begin bad++; $display("[TB] FAIL rst_owner: got %b expected 0", bus.owner); end
    reset = 1'b0;
    step();
  endtask

  // Full turn for requester 0 ending by expiry; edge-by-edge expectations.
  task automatic test_single_turn();
    int   t0;
    int   e0;
    logic exp_en;
    logic exp_to;
    logic exp_busy;
    logic exp_go;
    logic [1:0] exp_grant;
    t0 = to_seen;
    e0 = en_seen;
    bus.req = 2'b01;
    step();
    total += 3;
    if (bus.grant !== 2'b01) begin bad++; $display("[TB] FAIL load_grant: got %b expected 01", bus.grant); end
    if (bus.cnt_go !== 1'b1) begin bad++; $display("[TB] FAIL load_go: got %b expected 1", bus.cnt_go); end
    if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL load_busy: got %b expected 1", bus.busy); end
    for (int e = 2; e <= 17; e++) begin
      step();
      exp_en    = (e == 5) || (e == 9) || (e == 13);
      exp_to    = (e == 15);
      exp_grant = (e <= 15) ? 2'b01 : 2'b00;
      exp_busy  = (e <= 16);
      exp_go    = (e == 17);
      total += 5;
      if (bus.cnt_en !== exp_en) begin bad++; $display("[TB] FAIL turn_en@%0d: got %b expected %b", e, bus.cnt_en, exp_en); end
      if (bus.timeout !== exp_to) begin bad++; $display("[TB] FAIL turn_timeout@%0d: got %b expected %b", e, bus.timeout, exp_to); end
      if (bus.grant !== exp_grant) begin bad++; $display("[TB] FAIL turn_grant@%0d: got %b expected %b", e, bus.grant, exp_grant); end
      if (bus.busy !== exp_busy) begin bad++; $display("[TB] FAIL turn_busy@%0d: got %b expected %b", e, bus.busy, exp_busy); end
      if (bus.cnt_go !== exp_go) begin bad++; $display("[TB] FAIL turn_go@%0d: got %b expected %b", e, bus.cnt_go, exp_go); end
      if (e == 14) begin
        total++;
        if (cnt_model !== 16'd3) begin bad++; $display("[TB] FAIL turn_count14: got %0d expected 3", cnt_model); end
      end
    end
    bus.req = 2'b00;
    total += 2;
    if (to_seen - t0 !== 1) begin bad++; $display("[TB] FAIL turn_timeouts: got %0d expected 1", to_seen - t0); end
    if (en_seen - e0 !== 3) begin bad++; $display("[TB] FAIL turn_enables: got %0d expected 3", en_seen - e0); end
  endtask

  // Both requesting: alternating owners, each turn expiring, one IDLE gap.
  task automatic test_round_robin();
    logic [1:0] exp_grant [3];
    int k;
    int t0;
    exp_grant[0] = 2'b01;
    exp_grant[1] = 2'b10;
    exp_grant[2] = 2'b01;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      k = 0;
      while (bus.busy !== 1'b1 && k < 5) begin step(); k++; end
      t0 = to_seen;
      total += 1;
      if (bus.grant !== exp_grant[t]) begin bad++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", t, bus.grant, exp_grant[t]); end
      if (t == 2) bus.req = 2'b00;
      k = 0;
      while (bus.busy !== 1'b0 && k < 30) begin step(); k++; end
      total += 2;
      if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rr_end%0d: got busy %b expected 0", t, bus.busy); end
      if (to_seen - t0 !== 1) begin bad++; $display("[TB] FAIL rr_timeout%0d: got %0d expected 1", t, to_seen - t0); end
      step();
      total += 1;
      if (t < 2) begin
        if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL rr_gap%0d: got busy %b expected 1", t, bus.busy); end
      end else begin
        if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rr_stop: got busy %b expected 0", bus.busy); end
      end
    end
  endtask

  // Early done by the owner, then a non-owner done that must be ignored.
  task automatic test_early_done();
    int k;
    int t0;
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    k = 0;
    while (cnt_model !== 16'd1 && k < 20) begin step(); k++; end
    total += 1;
    if (cnt_model !== 16'd1) begin bad++; $display("[TB] FAIL done_wait: got count %0d expected 1", cnt_model); end
    t0 = to_seen;
    bus.done = 2'b01;
    step();
    bus.done = 2'b00;
    total += 3;
    if (bus.grant !== 2'b00) begin bad++; $display("[TB] FAIL done_grant: got %b expected 00", bus.grant); end
    if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL done_busy: got %b expected 1", bus.busy); end
    if (bus.timeout !== 1'b0) begin bad++; $display("[TB] FAIL done_timeout: got %b expected 0", bus.timeout); end
    step();
    total += 2;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL done_idle: got %b expected 0", bus.busy); end
    if (to_seen !== t0) begin bad++; $display("[TB] FAIL done_nopulse: got %0d expected %0d", to_seen, t0); end
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    bus.done = 2'b10;
    t0 = to_seen;
    total += 1;
    if (bus.grant !== 2'b01) begin bad++; $display("[TB] FAIL ndone_grant: got %b expected 01", bus.grant); end
    k = 0;
    while (bus.busy !== 1'b0 && k < 30) begin step(); k++; end
    bus.done = 2'b00;
    total += 2;
    if (to_seen - t0 !== 1) begin bad++; $display("[TB] FAIL ndone_timeout: got %0d expected 1", to_seen - t0); end
    if (k !== 16) begin bad++; $display("[TB] FAIL ndone_len: got %0d expected 16", k); end
  endtask

  // Owner done in the same cycle as expiry: expiry wins.
  task automatic test_done_at_expiry();
    int k;
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    k = 0;
    while (cnt_model !== 16'd3 && k < 30) begin step(); k++; end
    total += 1;
    if (cnt_model !== 16'd3) begin bad++; $display("[TB] FAIL dx_wait: got count %0d expected 3", cnt_model); end
    bus.done = 2'b01;
    step();
    bus.done = 2'b00;
    total += 2;
    if (bus.timeout !== 1'b1) begin bad++; $display("[TB] FAIL dx_timeout: got %b expected 1", bus.timeout); end
    if (bus.grant !== 2'b01) begin bad++; $display("[TB] FAIL dx_grant: got %b expected 01", bus.grant); end
    step();
    total += 3;
    if (bus.timeout !== 1'b0) begin bad++; $display("[TB] FAIL dx_rel_timeout: got %b expected 0", bus.timeout); end
    if (bus.grant !== 2'b00) begin bad++; $display("[TB] FAIL dx_rel_grant: got %b expected 00", bus.grant); end
    if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL dx_rel_busy: got %b expected 1", bus.busy); end
    step();
    total += 1;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL dx_idle: got %b expected 0", bus.busy); end
  endtask

  // Reset during RUN of owner 1 aborts the turn and clears the pointer.
  task automatic test_reset_mid_run();
    int k;
    int t0;
    bus.req = 2'b10;
    step();
    bus.req = 2'b00;
    total += 1;
    if (bus.grant !== 2'b10) begin bad++; $display("[TB] FAIL mr_grant: got %b expected 10", bus.grant); end
    k = 0;
    while (cnt_model !== 16'd2 && k < 20) begin step(); k++; end
    total += 1;
    if (cnt_model !== 16'd2) begin bad++; $display("[TB] FAIL mr_wait: got count %0d expected 2", cnt_model); end
    t0 = to_seen;
    reset = 1'b1;
    step();
    total += 5;
    if (bus.grant !== 2'b00) begin bad++; $display("[TB] FAIL mr_rgrant: got %b expected 00", bus.grant); end
    if (bus.cnt_go !== 1'b1) begin bad++; $display("[TB] FAIL mr_rgo: got %b expected 1", bus.cnt_go); end
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mr_rbusy: got %b expected 0", bus.busy); end
    if (bus.timeout !== 1'b0) begin bad++; $display("[TB] FAIL mr_rtimeout: got %b expected 0", bus.timeout); end
    if (to_seen !== t0) begin bad++; $display("[TB] FAIL mr_nopulse: got %0d expected %0d", to_seen, t0); end
    reset = 1'b0;
    bus.req = 2'b11;
    step();
    bus.req = 2'b00;
    total += 1;
    if (bus.grant !== 2'b01) begin bad++; $display("[TB] FAIL mr_rr: got %b expected 01", bus.grant); end
    k = 0;
    while (bus.busy !== 1'b0 && k < 30) begin step(); k++; end
    total += 1;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mr_finish: got busy %b expected 0", bus.busy); end
  endtask

`ifdef TURN_TIMER_PAUSE_EN
  // Pause in RUN freezes the prescaler phase for its duration.
  task automatic test_pause();
    int k;
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    step();
    step();
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (bus.cnt_en !== 1'b0) begin bad++; $display("[TB] FAIL pause_en%0d: got %b expected 0", i, bus.cnt_en); end
    end
    bus.pause = 1'b0;
    step();
    total++;
    if (bus.cnt_en !== 1'b0) begin bad++; $display("[TB] FAIL pause_ph2: got %b expected 0", bus.cnt_en); end
    step();
    total++;
    if (bus.cnt_en !== 1'b1) begin bad++; $display("[TB] FAIL pause_ph3: got %b expected 1", bus.cnt_en); end
    k = 0;
    while (bus.busy !== 1'b0 && k < 30) begin step(); k++; end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL pause_finish: got busy %b expected 0", bus.busy); end
  endtask
`endif

  // Scenario sequence and summary.
  initial begin
    total    = 0;
    bad      = 0;
    to_seen  = 0;
    en_seen  = 0;
    reset    = 1'b1;
    bus.req  = 2'b00;
    bus.done = 2'b00;
`ifdef TURN_TIMER_PAUSE_EN
    bus.pause = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_single_turn();
    test_round_robin();
    test_early_done();
    test_done_at_expiry();
    test_reset_mid_run();
`ifdef TURN_TIMER_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
